// File: rtl/data_ram_ctrl.sv
// Byte-addressable big-endian data RAM with programmable wait states and MOC handshake.
// Define ALIGN_CHECK_EN to reject misaligned half/word/double-word accesses.
module data_ram_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Enable,
  input  logic        ReadWrite,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  input  logic [1:0]  DataType,
  output logic [31:0] DataOut,
  output logic        MOC,
  output logic        Busy,
  output logic        AddrError
);

  localparam int unsigned Depth    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WaitLoad = 4'(WAIT_STATES);
  localparam logic [1:0]  DtByte   = 2'b00;
  localparam logic [1:0]  DtHalf   = 2'b01;
  localparam logic [1:0]  DtDword  = 2'b11;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  logic [7:0]  mem [Depth];

  state_e      state_q, state_d;
  addr_t       addr_q;
  logic [1:0]  dtype_q;
  logic        read_q;
  logic        beat_q, beat_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_out_q;
  logic        moc_q;

  logic        do_beat;
  logic        reject;
  logic        misaligned;
  addr_t       beat_addr, a0, a1, a2, a3;
  logic [31:0] rdata;

  logic        unused_addr;
  assign unused_addr = ^Address[31:ADDR_WIDTH];

  // Second beat of a double-word sits 4 bytes up; all byte lanes wrap at the RAM size.
  assign beat_addr = addr_q + (beat_q ? addr_t'(4) : addr_t'(0));
  assign a0 = beat_addr;
  assign a1 = beat_addr + addr_t'(1);
  assign a2 = beat_addr + addr_t'(2);
  assign a3 = beat_addr + addr_t'(3);

`ifdef ALIGN_CHECK_EN
  logic addr_err_q;

  assign misaligned = ((dtype_q == DtHalf) && addr_q[0]) ||
                      (dtype_q[1] && (addr_q[1:0] != 2'b00));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= reject;
    end
  end

  assign AddrError = addr_err_q;
`else
  assign misaligned = 1'b0;
  assign AddrError  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    do_beat = 1'b0;
    reject  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Enable) begin
          state_d = StWait;
          cnt_d   = WaitLoad;
          beat_d  = 1'b0;
        end
      end
      StWait: begin
        if (!Enable) begin
          state_d = StIdle;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (misaligned && !beat_q) begin
          reject  = 1'b1;
          state_d = StDone;
        end else begin
          do_beat = 1'b1;
          if ((dtype_q == DtDword) && !beat_q) begin
            beat_d = 1'b1;
            cnt_d  = WaitLoad;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // Hold here until Enable drops so one assertion gives one transaction.
        if (!Enable) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata = {mem[a0], mem[a1], mem[a2], mem[a3]};
    case (dtype_q)
      DtByte:  rdata = {24'b0, mem[a0]};
      DtHalf:  rdata = {16'b0, mem[a0], mem[a1]};
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      dtype_q    <= DtByte;
      read_q     <= 1'b0;
      beat_q     <= 1'b0;
      cnt_q      <= 4'd0;
      data_out_q <= 32'd0;
      moc_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      moc_q   <= do_beat | reject;
      if ((state_q == StIdle) && Enable) begin
        addr_q  <= Address[ADDR_WIDTH-1:0];
        dtype_q <= DataType;
        read_q  <= ReadWrite;
      end
      if (do_beat && read_q) begin
        data_out_q <= rdata;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge Clk) begin
    if (do_beat && !read_q) begin
      case (dtype_q)
        DtByte: begin
          mem[a0] <= DataIn[7:0];
        end
        DtHalf: begin
          mem[a0] <= DataIn[15:8];
          mem[a1] <= DataIn[7:0];
        end
        default: begin
          mem[a0] <= DataIn[31:24];
          mem[a1] <= DataIn[23:16];
          mem[a2] <= DataIn[15:8];
          mem[a3] <= DataIn[7:0];
        end
      endcase
    end
  end

  assign DataOut = data_out_q;
  assign MOC     = moc_q;
  assign Busy    = (state_q == StWait);

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench for data_ram_ctrl: directed vector table, corner sequences, and
// random transactions against a byte-array memory model.
module tb_data_ram_ctrl;

  localparam int unsigned AW    = 9;
  localparam int unsigned WS    = 2;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int          NV    = 15;

`ifdef ALIGN_CHECK_EN
  localparam bit AC = 1'b1;
`else
  localparam bit AC = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Enable = 1'b0;
  logic        ReadWrite = 1'b0;
  logic [31:0] Address = 32'd0;
  logic [31:0] DataIn = 32'd0;
  logic [1:0]  DataType = 2'b00;
  logic [31:0] DataOut;
  logic        MOC;
  logic        Busy;
  logic        AddrError;

  data_ram_ctrl #(
    .ADDR_WIDTH  (AW),
    .WAIT_STATES (WS)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Enable    (Enable),
    .ReadWrite (ReadWrite),
    .Address   (Address),
    .DataIn    (DataIn),
    .DataType  (DataType),
    .DataOut   (DataOut),
    .MOC       (MOC),
    .Busy      (Busy),
    .AddrError (AddrError)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [1:0]  dt;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        err;
  } vec_t;

  vec_t        tbl [NV];
  int          total = 0;
  int          bad = 0;
  logic [7:0]  mem_m [DEPTH];
  logic [31:0] dout_m = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] wrap(input logic [31:0] a, input int off);
    logic [31:0] s;
    s = a + 32'(off);
    return s[AW-1:0];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] dt);
    logic [31:0] w;
    w = {mem_m[wrap(a, 0)], mem_m[wrap(a, 1)], mem_m[wrap(a, 2)], mem_m[wrap(a, 3)]};
    if (dt == 2'b00) return {24'b0, w[31:24]};
    if (dt == 2'b01) return {16'b0, w[31:16]};
    return w;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [1:0] dt, input logic [31:0] d);
    if (dt == 2'b00) begin
      mem_m[wrap(a, 0)] = d[7:0];
    end else if (dt == 2'b01) begin
      mem_m[wrap(a, 0)] = d[15:8];
      mem_m[wrap(a, 1)] = d[7:0];
    end else begin
      for (int i = 0; i < 4; i++) mem_m[wrap(a, i)] = d[31-8*i -: 8];
    end
  endtask

  function automatic bit m_rejects(input logic [31:0] a, input logic [1:0] dt);
    bit r;
    r = 1'b0;
`ifdef ALIGN_CHECK_EN
    if (dt == 2'b01) r = a[0];
    if (dt[1]) r = (a[1:0] != 2'b00);
`endif
    return r && (dt <= 2'b11);
  endfunction

  function automatic vec_t mk(input logic rw, input logic [31:0] addr, input logic [1:0] dt,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] e0, input logic [31:0] e1, input logic err);
    vec_t v;
    v.rw = rw; v.addr = addr; v.dt = dt; v.d0 = d0; v.d1 = d1;
    v.e0 = e0; v.e1 = e1; v.err = err;
    return v;
  endfunction

  // Called one time unit after a rising edge; returns one time unit after a rising edge.
  task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [1:0] dt,
                         input logic [31:0] d0, input logic [31:0] d1, input bit drop,
                         output logic [31:0] out0, output logic [31:0] out1,
                         output logic err);
    bit          rej;
    bit          dropped;
    int          nb;
    int          n;
    int          seen;
    logic [31:0] ba;
    rej     = m_rejects(addr, dt);
    nb      = (dt == 2'b11 && !rej) ? 2 : 1;
    dropped = 1'b0;
    out0    = DataOut;
    out1    = DataOut;
    err     = 1'b0;
    ReadWrite = rw;
    Address   = addr;
    DataType  = dt;
    DataIn    = d0;
    Enable    = 1'b1;
    for (int b = 0; b < nb; b++) begin
      if (b == 0) @(posedge Clk);
      n = 0;
      do begin
        @(posedge Clk);
        #1;
        n++;
        if (n == 1 && !MOC) chk("busy_wait", Busy, 1'b1);
      end while (!MOC && n < 40);
      chk("moc_latency", n, WS + 1);
      chk("addr_error", AddrError, rej);
      chk("busy_at_moc", Busy, (nb == 2 && b == 0));
      err = err | AddrError;
      if (!rej) begin
        ba = addr + 32'(4 * b);
        if (rw) dout_m = m_read(ba, dt);
        else m_write(ba, dt, (b == 0) ? d0 : d1);
      end
      chk("data_out", DataOut, dout_m);
      if (b == 0) out0 = DataOut;
      else out1 = DataOut;
      if (b == 0 && nb == 2) begin
        DataIn = d1;
        if (drop) begin
          Enable  = 1'b0;
          dropped = 1'b1;
          break;
        end
      end
    end
    if (dropped) begin
      seen = 0;
      for (int c = 0; c < int'(WS) + 3; c++) begin
        @(posedge Clk);
        #1;
        if (MOC) seen++;
      end
      chk("abort_no_moc", seen, 0);
      chk("abort_busy", Busy, 1'b0);
    end else begin
      // Enable still high: must stay parked, not restart.
      for (int c = 0; c < 2; c++) begin
        @(posedge Clk);
        #1;
        chk("moc_one_cycle", MOC, 1'b0);
        chk("busy_done", Busy, 1'b0);
      end
      Enable = 1'b0;
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] o0, o1, ra, rx, ry;
    logic        e, rrw;
    logic [1:0]  rdt;

    repeat (3) @(posedge Clk);
    #1;
    chk("reset_dataout", DataOut, 32'd0);
    chk("reset_moc", MOC, 1'b0);
    chk("reset_busy", Busy, 1'b0);
    chk("reset_addrerr", AddrError, 1'b0);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    for (int i = 0; i < int'(DEPTH); i += 4) begin
      run_txn(1'b0, 32'(i), 2'b10, 32'd0, 32'd0, 1'b0, o0, o1, e);
    end

    tbl[0]  = mk(0, 32'h010, 2'b10, 32'hDEADBEEF, 0, 0, 0, 0);
    tbl[1]  = mk(1, 32'h011, 2'b00, 0, 0, 32'h000000AD, 0, 0);
    tbl[2]  = mk(0, 32'h020, 2'b01, 32'h00001234, 0, 0, 0, 0);
    tbl[3]  = mk(1, 32'h020, 2'b10, 0, 0, 32'h12340000, 0, 0);
    tbl[4]  = mk(0, 32'h040, 2'b11, 32'h11223344, 32'h55667788, 0, 0, 0);
    tbl[5]  = mk(1, 32'h040, 2'b11, 0, 0, 32'h11223344, 32'h55667788, 0);
    tbl[6]  = mk(1, 32'h044, 2'b10, 0, 0, 32'h55667788, 0, 0);
    tbl[7]  = mk(1, 32'hFFFFFE10, 2'b10, 0, 0, 32'hDEADBEEF, 0, 0);
    tbl[8]  = mk(0, 32'h1FF, 2'b10, 32'hA1B2C3D4, 0, 0, 0, AC);
    tbl[9]  = mk(1, 32'h1FF, 2'b00, 0, 0, AC ? 32'h0 : 32'h000000A1, 0, 0);
    tbl[10] = mk(1, 32'h000, 2'b00, 0, 0, AC ? 32'h0 : 32'h000000B2, 0, 0);
    tbl[11] = mk(1, 32'h002, 2'b00, 0, 0, AC ? 32'h0 : 32'h000000D4, 0, 0);
    tbl[12] = mk(1, 32'h013, 2'b10, 0, 0, AC ? 32'h0 : 32'hEF000000, 0, AC);
    tbl[13] = mk(1, 32'h021, 2'b01, 0, 0, AC ? 32'h0 : 32'h00003400, 0, AC);
    tbl[14] = mk(1, 32'h020, 2'b01, 0, 0, 32'h00001234, 0, 0);

    for (int i = 0; i < NV; i++) begin
      run_txn(tbl[i].rw, tbl[i].addr, tbl[i].dt, tbl[i].d0, tbl[i].d1, 1'b0, o0, o1, e);
      chk($sformatf("vec%0d_err", i), e, tbl[i].err);
      if (tbl[i].rw) begin
        chk($sformatf("vec%0d_out0", i), o0, tbl[i].e0);
        if (tbl[i].dt == 2'b11) chk($sformatf("vec%0d_out1", i), o1, tbl[i].e1);
      end
    end

    // Double-word write abandoned after its first beat.
    run_txn(1'b0, 32'h080, 2'b11, 32'hCAFEBABE, 32'h01020304, 1'b1, o0, o1, e);
    run_txn(1'b1, 32'h084, 2'b10, 0, 0, 1'b0, o0, o1, e);
    chk("abort_beat1_unwritten", o0, 32'h00000000);
    run_txn(1'b1, 32'h080, 2'b10, 0, 0, 1'b0, o0, o1, e);
    chk("abort_beat0_written", o0, 32'hCAFEBABE);

    // Asynchronous reset while a write is still waiting.
    ReadWrite = 1'b0;
    Address   = 32'h090;
    DataType  = 2'b10;
    DataIn    = 32'h77777777;
    Enable    = 1'b1;
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    chk("busy_mid_wait", Busy, 1'b1);
    Reset_n = 1'b0;
    #1;
    chk("async_rst_dataout", DataOut, 32'd0);
    chk("async_rst_moc", MOC, 1'b0);
    chk("async_rst_busy", Busy, 1'b0);
    chk("async_rst_addrerr", AddrError, 1'b0);
    Enable = 1'b0;
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    dout_m  = 32'd0;
    @(posedge Clk);
    #1;
    run_txn(1'b1, 32'h090, 2'b10, 0, 0, 1'b0, o0, o1, e);
    chk("rst_discarded_write", o0, 32'h00000000);

    for (int i = 0; i < 150; i++) begin
      rrw = 1'($urandom_range(0, 1));
      rdt = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rx  = $urandom;
      ry  = $urandom;
      run_txn(rrw, ra, rdt, rx, ry, 1'b0, o0, o1, e);
      chk("rnd_err", e, m_rejects(ra, rdt));
    end

    for (int i = 0; i < int'(DEPTH); i += 4) begin
      run_txn(1'b1, 32'(i), 2'b10, 0, 0, 1'b0, o0, o1, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
